// File: rtl/dm_responder_if.sv
// Data-memory bus between the MEM-stage initiator and the multi-cycle
// responder: request fields out, completion pulse and load data back.
interface dm_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, addr, we, be, wd,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, addr, we, be, wd,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder. A request is latched in IDLE, held for
// LAT cycles, then the access is performed and ready pulses for one cycle.
// After reset the array is zeroed one word per cycle before any request is
// accepted. AW must satisfy 2**AW >= DEPTH; LAT must lie in 1..15.
module dm_responder #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12,
  parameter int LAT   = 2
) (
  input logic clk,
  input logic reset,
  dm_responder_if.slave bus
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0]   ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
  localparam logic [3:0]    CNT_LOAD   = 4'(LAT - 1);

  state_t state;
  state_t next_state;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] clear_idx;
  logic [3:0]    cnt;

  logic [31:0]   lat_addr;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wd;

  logic [31:0]   rdata_q;
  logic          err_q;
  logic          ready_q;
  logic          busy_q;

  logic [AW-1:0] word_idx;
  logic          out_of_range;
  logic          access_now;

  // The range check sees the whole 32-bit address so high garbage bits
  // cannot alias onto a valid word.
  assign word_idx     = lat_addr[AW+1:2];
  assign out_of_range = (lat_addr >= ADDR_LIMIT);
  assign access_now   = (state == WAIT) && (cnt == 4'd0);

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

  // State register; reset always restarts the clearing sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  // Next-state logic for the clear / accept / wait / complete sequence.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clear_idx == LAST_IDX) next_state = IDLE;
      IDLE:    if (bus.req) next_state = WAIT;
      WAIT:    if (cnt == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = CLEAR;
    endcase
  end

  // Registered status outputs, derived from the state being entered so that
  // ready lines up exactly with DONE and busy with any non-IDLE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      ready_q <= (next_state == DONE);
      busy_q  <= (next_state != IDLE);
    end
  end

  // Clear index, latency counter, request latch and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_idx <= '0;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_wd    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        CLEAR: clear_idx <= clear_idx + 1'b1;
        IDLE: begin
          if (bus.req) begin
            lat_addr <= bus.addr;
            lat_we   <= bus.we;
            lat_be   <= bus.be;
            lat_wd   <= bus.wd;
            cnt      <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (out_of_range) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (lat_we) begin
            rdata_q <= '0;
          end else begin
            rdata_q <= mem[word_idx];
          end
        end
        DONE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Array writes: zero fill during CLEAR, byte-masked store at access time.
  // Nothing is written while reset is held, so an interrupted store is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clear_idx] <= '0;
      end else if (access_now && lat_we && !out_of_range) begin
        for (int i = 0; i < 4; i++) begin
          if (lat_be[i]) mem[word_idx][8*i +: 8] <= lat_wd[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with a 16-word array and two-cycle latency.
module tb_dm_responder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LAT   = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] rd;
  logic        e;
  int          ed;
  int          n;

  dm_responder_if bus();

  dm_responder #(.DEPTH(DEPTH), .AW(AW), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction: the request is presented after a falling edge,
  // accepted on the next rising edge, then ready is awaited for a bounded
  // number of edges. Latency and single-cycle pulse width are checked here.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d, output logic [31:0] rdo,
                               output logic eo, output int edges);
    @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.be = b; bus.wd = d;
    edges = 0; rdo = 'x; eo = 1'bx;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.ready) begin
        edges = i; rdo = bus.rdata; eo = bus.err;
        break;
      end
    end
    bus.req = 1'b0;
    checkOutput("latency", 32'(edges), 32'(LAT));
    @(posedge clk); #1;
    checkOutput("pulse_width", 32'(bus.ready), 32'd0);
  endtask

  task automatic waitClear(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (!bus.busy) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Directed sequence covering clear, masked stores, range errors,
  // back-to-back requests and reset in the middle of a store.
  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wd = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd1);
    checkOutput("rst_ready", 32'(bus.ready), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);

    @(negedge clk); reset = 1'b0;
    waitClear(n);
    checkOutput("clear_cycles", 32'(n), 32'(DEPTH));

    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus(1'b0, 32'(w * 4), 4'hF, 32'h0, rd, e, ed);
      checkOutput($sformatf("clr_word%0d", w), rd, 32'h0);
    end

    applyStimulus(1'b1, 32'h8, 4'b1111, 32'hDEADBEEF, rd, e, ed);
    checkOutput("st_full_rdata", rd, 32'h0);
    checkOutput("st_full_err", 32'(e), 32'd0);
    applyStimulus(1'b0, 32'h8, 4'b0000, 32'h0, rd, e, ed);
    checkOutput("ld_full", rd, 32'hDEADBEEF);
    checkOutput("ld_full_err", 32'(e), 32'd0);

    applyStimulus(1'b1, 32'h9, 4'b0010, 32'h55555555, rd, e, ed);
    applyStimulus(1'b0, 32'h8, 4'b1111, 32'h0, rd, e, ed);
    checkOutput("ld_byte", rd, 32'hDEAD55EF);

    applyStimulus(1'b1, 32'hA, 4'b1100, 32'h12341234, rd, e, ed);
    applyStimulus(1'b0, 32'h8, 4'b1111, 32'h0, rd, e, ed);
    checkOutput("ld_half", rd, 32'h123455EF);

    applyStimulus(1'b1, 32'h8, 4'b0000, 32'hFFFFFFFF, rd, e, ed);
    applyStimulus(1'b0, 32'h8, 4'b1111, 32'h0, rd, e, ed);
    checkOutput("ld_be0", rd, 32'h123455EF);

    applyStimulus(1'b1, 32'h3C, 4'b1111, 32'hA5A5C3C3, rd, e, ed);
    checkOutput("st_last_err", 32'(e), 32'd0);
    applyStimulus(1'b0, 32'h3F, 4'b0000, 32'h0, rd, e, ed);
    checkOutput("ld_last", rd, 32'hA5A5C3C3);
    checkOutput("ld_last_err", 32'(e), 32'd0);

    applyStimulus(1'b0, 32'h40, 4'b1111, 32'h0, rd, e, ed);
    checkOutput("ld_oor_err", 32'(e), 32'd1);
    checkOutput("ld_oor_rdata", rd, 32'h0);
    applyStimulus(1'b1, 32'h40, 4'b1111, 32'hFFFFFFFF, rd, e, ed);
    checkOutput("st_oor_err", 32'(e), 32'd1);
    applyStimulus(1'b1, 32'h1000_0008, 4'b1111, 32'hFFFFFFFF, rd, e, ed);
    checkOutput("st_hi_err", 32'(e), 32'd1);
    applyStimulus(1'b0, 32'h1000_0008, 4'b1111, 32'h0, rd, e, ed);
    checkOutput("ld_hi_err", 32'(e), 32'd1);
    checkOutput("ld_hi_rdata", rd, 32'h0);
    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus(1'b0, 32'(w * 4), 4'hF, 32'h0, rd, e, ed);
      checkOutput($sformatf("oor_word%0d", w), rd,
                  (w == 2) ? 32'h123455EF : (w == 15) ? 32'hA5A5C3C3 : 32'h0);
    end

    // req held high: accepts at E0, E4, E8; ready seen after E2, E6, E10.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h8; bus.be = 4'hF; bus.wd = '0;
    @(posedge clk); #1;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("b2b_ready_e%0d", i), 32'(bus.ready), (i % 4 == 2) ? 32'd1 : 32'd0);
      if (i % 4 == 2) checkOutput($sformatf("b2b_rdata_e%0d", i), bus.rdata, 32'h123455EF);
    end
    bus.req = 1'b0;

    // Reset lands while a store to word 1 is one edge from being written.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h4; bus.be = 4'hF; bus.wd = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; bus.req = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(bus.ready), 32'd0);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("mid_rst_hold%0d", i), 32'(bus.ready), 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    waitClear(n);
    checkOutput("reclear_cycles", 32'(n), 32'(DEPTH));
    applyStimulus(1'b0, 32'h4, 4'hF, 32'h0, rd, e, ed);
    checkOutput("ld_after_rst4", rd, 32'h0);
    applyStimulus(1'b0, 32'h8, 4'hF, 32'h0, rd, e, ed);
    checkOutput("ld_after_rst8", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Target-side data-memory responder for the pipeline's MEM-stage store/load bus (addr / WE / BE / WD out, read data back).
- Replaces the zero-wait-state DM with a multi-cycle responder using a req/ready handshake and a configurable access latency, so the pipeline's stall logic can be exercised against slow memory.
- Word-organised array with per-byte write enables.
- Clears its own contents after reset.

Parameters:
- DEPTH, 3072: number of 32-bit words; valid byte addresses are 0 to DEPTH*4-1.
- AW, 12: word-index width; must satisfy 2^AW >= DEPTH.
- LAT, 2: access latency in cycles from acceptance to ready; legal range 1 to 15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request valid; held high with fields stable until ready is seen.
- addr  in  32  byte address; bits [1:0] ignored (BE selects lanes).
- we  in  1  1 = store, 0 = load.
- be  in  4  byte-lane enables for stores; be[0] = bits [7:0]; ignored on loads.
- wd  in  32  store data, already lane-replicated by the initiator.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  load data; valid while ready is high.
- err  out  1  address out of range; valid while ready is high.
- busy  out  1  high while not in IDLE (includes CLEAR).

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - state = CLEAR, clear index = 0, cnt = 0.
  - ready = 0, err = 0, rdata = 0.
  - busy = 1.
  - Any latched request is discarded. A store in flight at reset is never written.
- States: CLEAR, IDLE, WAIT, DONE.
- CLEAR:
  - Each edge writes 0 to word[clear index] and increments the index.
  - After writing word DEPTH-1, go to IDLE.
  - Takes exactly DEPTH cycles after reset deasserts. req is ignored throughout.
- IDLE:
  - On an edge with req = 1: latch addr, we, be, wd; load cnt = LAT-1; go to WAIT.
  - On an edge with req = 0: stay in IDLE.
- WAIT:
  - At each edge with cnt != 0: cnt decrements.
  - At the edge with cnt == 0, perform the access, then go to DONE. The access is:
    - Range check uses the full 32-bit latched address: out of range if addr >= DEPTH*4. Then err <= 1, rdata <= 0, and no array write.
    - In-range store: for each i with be[i] = 1, byte lane i of word[addr[AW+1:2]] takes wd lane i; other lanes unchanged. rdata <= 0.
    - In-range load: rdata <= word[addr[AW+1:2]] (full word; extension is the initiator's job).
- DONE:
  - ready = 1 for exactly one cycle; rdata and err are valid only in this cycle.
  - Next edge: go to IDLE and clear ready, err and rdata to 0.
  - req is not sampled in DONE. A request still held high is accepted on the next IDLE edge as a new transaction.
- Latency: request accepted at edge E0 gives ready high in the cycle after edge E0+LAT. Back-to-back throughput is one transaction per LAT+2 cycles.
- Edge cases:
  - Store with be = 0000: completes normally, array unchanged.
  - Load returns contents after any store completed earlier; there is no read-during-write race because only one transaction is in flight.
- busy = (state != IDLE), registered.

Test Plan:
- Reset (DEPTH = 16 for the bench) -> busy = 1 for exactly 16 cycles after deassert; then loads of words 0..15 all return 0.
- LAT = 2: store addr = 0x8, be = 1111, wd = 0xDEADBEEF accepted at E0 -> ready high only in the cycle after E0+2. A subsequent load of 0x8 returns 0xDEADBEEF, err = 0.
- Byte store addr = 0x9, be = 0010, wd = 0x55555555 onto word 0xDEADBEEF -> load 0x8 returns 0xDEAD55EF. Half store be = 1100, wd = 0x12341234 -> 0x123455EF.
- Load addr = 0x40 (DEPTH = 16) -> ready with err = 1, rdata = 0. A store to 0x40 leaves every word unchanged.
- req held high across two transactions -> second accepted on the edge after DONE. ready pulses are LAT+2 cycles apart and never two cycles wide.
- Reset asserted while in WAIT on a store to 0x4 with wd = 0xFFFFFFFF -> ready stays 0, CLEAR reruns, and load 0x4 afterwards returns 0.
